exe_muldiv_unit: RTL and testbench

EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

---
 rtl/exe_muldiv_pkg.sv | 19 +
 rtl/exe_div_step.sv | 19 +
 rtl/exe_muldiv_unit.sv | 130 +++++++++++++
 tb/tb_exe_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// rtl/exe_muldiv_pkg.sv - opcode constants, FSM state encoding and configuration check for exe_muldiv_unit
package exe_muldiv_pkg;

    localparam logic [1:0] OP_MUL_LO = 2'b00;
    localparam logic [1:0] OP_MUL_HI = 2'b01;
    localparam logic [1:0] OP_DIV    = 2'b10;
    localparam logic [1:0] OP_REM    = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic bit mul_bits_legal(input int width, input int mul_bits);
        return (mul_bits == 1 || mul_bits == 2 || mul_bits == 4)
            && (width % mul_bits == 0) && (width >= 8) && (width % 2 == 0);
    endfunction

endpackage

// File: rtl/exe_div_step.sv
// rtl/exe_div_step.sv - one combinational restoring-division step
module exe_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, dividend_bit};
    assign quo_bit = (shifted >= {1'b0, divisor});
    // rem_in < divisor keeps the true difference below divisor, so modulo-2^WIDTH wrap is exact.
    assign rem_out = quo_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - iterative shift-add multiplier / restoring divider; divider built only with EXE_MULDIV_DIVIDER_EN
module exe_muldiv_unit
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             cpuClock,
    input  logic             cpuReset,
    input  logic             stall,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             divByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_STEPS = CNT_W'(WIDTH / MUL_BITS);

    generate
        if (!mul_bits_legal(WIDTH, MUL_BITS)) begin : g_cfg_check
            $error("exe_muldiv_unit: illegal WIDTH/MUL_BITS combination");
        end
    endgenerate

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    // Upper half: running sum / partial remainder. Lower half: multiplier / dividend shifting out.
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mcand;
    logic                 op_lo;
    logic                 accept;
    logic [WIDTH+MUL_BITS-1:0] mul_sum;
    logic [CNT_W-1:0]     div_steps;
    logic [WIDTH-1:0]     div_result;
    logic                 div_zero_flag;

    assign accept = start && !stall && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

    assign mul_sum = {{MUL_BITS{1'b0}}, prod[2*WIDTH-1:WIDTH]}
                   + ({{MUL_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[MUL_BITS-1:0]});

`ifdef EXE_MULDIV_DIVIDER_EN
    logic             dz_pend;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    exe_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (prod[2*WIDTH-1:WIDTH]),
        .divisor      (mcand),
        .dividend_bit (prod[WIDTH-1]),
        .rem_out      (div_rem),
        .quo_bit      (div_q)
    );

    assign div_steps     = dz_pend ? CNT_W'(1) : CNT_W'(WIDTH);
    assign div_zero_flag = dz_pend;

    always_comb begin
        div_result = '0;
        if (dz_pend)
            div_result = op_lo ? prod[WIDTH-1:0] : '1;
        else
            div_result = op_lo ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
`else
    assign div_steps     = CNT_W'(1);
    assign div_zero_flag = 1'b0;
    assign div_result    = '0;
`endif

    always_ff @(posedge cpuClock or posedge cpuReset) begin
        if (cpuReset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            op_lo     <= 1'b0;
            result    <= '0;
            divByZero <= 1'b0;
`ifdef EXE_MULDIV_DIVIDER_EN
            dz_pend   <= 1'b0;
`endif
        end else if (accept) begin
            state     <= opcode[1] ? ST_DIV : ST_MUL;
            cnt       <= '0;
            prod      <= {{WIDTH{1'b0}}, (opcode[1] ? operandA : operandB)};
            mcand     <= opcode[1] ? operandB : operandA;
            op_lo     <= opcode[0];
            divByZero <= 1'b0;
`ifdef EXE_MULDIV_DIVIDER_EN
            dz_pend   <= (operandB == '0);
`endif
        end else if (!stall) begin
            case (state)
                ST_MUL: begin
                    if (cnt == MUL_STEPS) begin
                        state  <= ST_DONE;
                        result <= op_lo ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:MUL_BITS]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt == div_steps) begin
                        state     <= ST_DONE;
                        result    <= div_result;
                        divByZero <= div_zero_flag;
                    end else begin
`ifdef EXE_MULDIV_DIVIDER_EN
                        // A zero divisor leaves the dividend in place as the remainder.
                        if (!dz_pend)
                            prod <= {div_rem, prod[WIDTH-2:0], div_q};
`endif
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb/tb_exe_muldiv_unit.sv - self-checking bench for exe_muldiv_unit (MUL_BITS 1 and 4 instances)
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        start1;
    logic        start4;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy1, done1, dz1;
    logic [31:0] res1;
    logic        busy4, done4, dz4;
    logic [31:0] res4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    exe_muldiv_unit #(.WIDTH(32), .MUL_BITS(1)) dut1 (
        .cpuClock(clk), .cpuReset(rst), .stall(stall), .start(start1), .opcode(opcode),
        .operandA(a), .operandB(b), .busy(busy1), .done(done1), .result(res1), .divByZero(dz1)
    );

    exe_muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .cpuClock(clk), .cpuReset(rst), .stall(stall), .start(start4), .opcode(opcode),
        .operandA(a), .operandB(b), .busy(busy4), .done(done4), .result(res4), .divByZero(dz4)
    );

    typedef struct {
        int          which;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: {divByZero, result} from plain arithmetic.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] ones;
        p = {32'b0, x} * {32'b0, y};
        ones = '1;
        case (op)
            2'b00: return {1'b0, p[31:0]};
            2'b01: return {1'b0, p[63:32]};
`ifdef EXE_MULDIV_DIVIDER_EN
            2'b10: return (y == 0) ? {1'b1, ones} : {1'b0, x / y};
            default: return (y == 0) ? {1'b1, x} : {1'b0, x % y};
`else
            default: return 33'd0;
`endif
        endcase
    endfunction

    function automatic int model_lat(input int which, input logic [1:0] op, input logic [31:0] y);
        if (!op[1]) return 32 / which + 1;
`ifdef EXE_MULDIV_DIVIDER_EN
        return (y == 0) ? 2 : 33;
`else
        return (y == 0) ? 2 : 2;
`endif
    endfunction

    task automatic wait_done(input int which, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if ((which == 4) ? done4 : done1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input int which, input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob,
                          input int stall_from, input int stall_len,
                          output int lat, output logic [31:0] r, output logic z);
        @(negedge clk);
        opcode = op;
        a = oa;
        b = ob;
        if (which == 4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k - 1 == stall_from) stall = 1'b1;
            if (k - 1 == stall_from + stall_len) stall = 1'b0;
            @(posedge clk); #1;
            if ((which == 4) ? done4 : done1) begin
                lat = k;
                break;
            end
        end
        stall = 1'b0;
        r = (which == 4) ? res4 : res1;
        z = (which == 4) ? dz4 : dz1;
    endtask

    initial begin
        int          lat;
        logic [31:0] r;
        logic        z;
        logic [32:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          w;

        rst = 1'b1;
        stall = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        opcode = 2'b00;
        a = '0;
        b = '0;
        #12;
        check("reset_busy", {busy1, busy4}, 2'b00);
        check("reset_done", {done1, done4}, 2'b00);
        check("reset_result", {res1, res4}, 64'd0);
        check("reset_dz", {dz1, dz4}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{1, 2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 33});
        vecs.push_back('{4, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 9});
        vecs.push_back('{4, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 9});
        vecs.push_back('{1, 2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0, 33});
`ifdef EXE_MULDIV_DIVIDER_EN
        vecs.push_back('{1, 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 33});
        vecs.push_back('{1, 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33});
        vecs.push_back('{1, 2'b10, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 2});
        vecs.push_back('{1, 2'b11, 32'd100, 32'd0, 32'd100, 1'b1, 2});
        vecs.push_back('{4, 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 33});
`else
        vecs.push_back('{1, 2'b10, 32'd100, 32'd7, 32'd0, 1'b0, 2});
        vecs.push_back('{1, 2'b11, 32'd100, 32'd7, 32'd0, 1'b0, 2});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].which, vecs[i].op, vecs[i].a, vecs[i].b, -1, 0, lat, r, z);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_dz", i), z, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 1 : 4;
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            exp = model(rop, ra, rb);
            run_op(w, rop, ra, rb, -1, 0, lat, r, z);
            check($sformatf("rand%0d_result op%0d", i, rop), r, exp[31:0]);
            check($sformatf("rand%0d_dz", i), z, exp[32]);
            check($sformatf("rand%0d_latency", i), lat, model_lat(w, rop, rb));
        end

        // Five stall cycles in the middle of a multiply.
        run_op(1, 2'b00, 32'd123457, 32'd1001, 10, 5, lat, r, z);
        check("stall_mul_result", r, 32'd123580457);
        check("stall_mul_latency", lat, 38);

        // Completion held under stall, ignored start, then back-to-back on release.
        run_op(1, 2'b00, 32'd6, 32'd9, -1, 0, lat, r, z);
        stall = 1'b1;
        opcode = 2'b01;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_done_held", done1, 1'b1);
        check("stall_done_result", res1, 32'd54);
        stall = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b_done_drop", {done1, busy1}, 2'b01);
        wait_done(1, lat);
        check("b2b_result", res1, 32'hFFFF_FFFE);
        check("b2b_latency", lat, 33);

        // Start during an operation must not disturb it.
        @(negedge clk);
        opcode = 2'b00;
        a = 32'd1234;
        b = 32'd1000;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        opcode = 2'b01;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1, lat);
        check("ignore_start_result", res1, 32'd1234000);
        check("ignore_start_latency", lat, 28);

        // Asynchronous reset between edges mid-operation.
`ifdef EXE_MULDIV_DIVIDER_EN
        rop = 2'b10;
`else
        rop = 2'b00;
`endif
        @(negedge clk);
        opcode = rop;
        a = 32'd100;
        b = 32'd7;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {busy1, done1, dz1, res1}, 35'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 2'b00, 32'd6, 32'd7, -1, 0, lat, r, z);
        check("post_reset_result", r, 32'd42);
        check("post_reset_latency", lat, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
